// File: rtl/mem_port_arbiter_pkg.sv
// +---------------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for mem_port_arbiter             |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// +---------------------------------------------------------------------------+
// | mem_port_arbiter_if : fetch, data and memory-port signals of the arbiter  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_data_in;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_data_out;

  // Core requesters and the memory model together form the master side.
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_funct3,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_address, mem_wren, mem_data_in, mem_funct3,
    output mem_data_out
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_funct3,
    output d_gnt, d_rvalid, d_rdata,
    output mem_address, mem_wren, mem_data_in, mem_funct3,
    input  mem_data_out
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
// +---------------------------------------------------------------------------+
// | arb_pick : combinational one-hot grant selection between fetch and data   |
// | Option macro: MEM_ARB_RR_EN (round-robin on ties). Rev 1.0                |
// +---------------------------------------------------------------------------+
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  wire logic       i_if_req,
  input  wire logic       i_d_req,
  input  wire arb_owner_t i_last_owner,
  input  wire logic       i_grant_ok,
  output logic            o_if_gnt,
  output logic            o_d_gnt
);

  always_comb begin
    o_if_gnt = 1'b0;
    o_d_gnt  = 1'b0;
    if (i_grant_ok) begin
`ifdef MEM_ARB_RR_EN
      if (i_if_req && i_d_req) begin
        // On a tie the requester that did not win last time goes first.
        if (i_last_owner == OWN_D) begin
          o_if_gnt = 1'b1;
        end else begin
          o_d_gnt = 1'b1;
        end
      end else begin
        o_if_gnt = i_if_req;
        o_d_gnt  = i_d_req;
      end
`else
      o_d_gnt  = i_d_req;
      o_if_gnt = i_if_req & ~i_d_req;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  logic w_unused_last_owner;
  assign w_unused_last_owner = (i_last_owner == OWN_IF);
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +---------------------------------------------------------------------------+
// | mem_port_arbiter : shares one synchronous memory port between IF and LSU  |
// | Option macro: MEM_ARB_RR_EN (round-robin on ties). Rev 1.0                |
// +---------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  arb_owner_t        r_owner;
  arb_owner_t        w_last_owner;

  logic              w_grant_ok;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_if_rvalid;
  logic              w_d_rvalid;
  logic [DATA_W-1:0] w_if_rdata;
  logic [DATA_W-1:0] w_d_rdata;

  logic [ADDR_W-1:0] r_mem_address;
  logic              r_mem_wren;
  logic [DATA_W-1:0] r_mem_data_in;
  logic [2:0]        r_mem_funct3;

  // A new grant may overlap the response cycle, giving one access per 2 cycles.
  assign w_grant_ok = (r_state == ARB_IDLE) || (r_state == ARB_RESP);

`ifdef MEM_ARB_RR_EN
  arb_owner_t r_last_owner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_owner <= OWN_D;
    end else if (w_d_gnt) begin
      r_last_owner <= OWN_D;
    end else if (w_if_gnt) begin
      r_last_owner <= OWN_IF;
    end
  end

  assign w_last_owner = r_last_owner;
`else
  assign w_last_owner = OWN_D;
`endif

  arb_pick u_arb_pick (
    .i_if_req     (bus.if_req),
    .i_d_req      (bus.d_req),
    .i_last_owner (w_last_owner),
    .i_grant_ok   (w_grant_ok),
    .o_if_gnt     (w_if_gnt),
    .o_d_gnt      (w_d_gnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE:   if (w_if_gnt || w_d_gnt) w_state_next = ARB_ACCESS;
      ARB_ACCESS: w_state_next = ARB_RESP;
      ARB_RESP:   w_state_next = (w_if_gnt || w_d_gnt) ? ARB_ACCESS : ARB_IDLE;
      default:    w_state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_if_rvalid = 1'b0;
    w_d_rvalid  = 1'b0;
    w_if_rdata  = '0;
    w_d_rdata   = '0;
    if (r_state == ARB_RESP) begin
      if (r_owner == OWN_IF) begin
        w_if_rvalid = 1'b1;
        w_if_rdata  = bus.mem_data_out;
      end else begin
        w_d_rvalid = 1'b1;
        w_d_rdata  = bus.mem_data_out;
      end
    end
  end

  // Write enable is re-evaluated every cycle so it can only be high in ACCESS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_address <= '0;
      r_mem_wren    <= 1'b0;
      r_mem_data_in <= '0;
      r_mem_funct3  <= FUNCT3_WORD;
      r_owner       <= OWN_D;
    end else begin
      r_mem_wren <= w_d_gnt & bus.d_we;
      if (w_d_gnt) begin
        r_mem_address <= bus.d_addr;
        r_mem_data_in <= bus.d_wdata;
        r_mem_funct3  <= bus.d_funct3;
        r_owner       <= OWN_D;
      end else if (w_if_gnt) begin
        r_mem_address <= bus.if_addr;
        r_mem_funct3  <= FUNCT3_WORD;
        r_owner       <= OWN_IF;
      end
    end
  end

  assign bus.if_gnt      = w_if_gnt;
  assign bus.d_gnt       = w_d_gnt;
  assign bus.if_rvalid   = w_if_rvalid;
  assign bus.if_rdata    = w_if_rdata;
  assign bus.d_rvalid    = w_d_rvalid;
  assign bus.d_rdata     = w_d_rdata;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wren    = r_mem_wren;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.mem_funct3  = r_mem_funct3;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +---------------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench with a word memory     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  logic clk;
  logic reset_n;

  int n_checks = 0;
  int n_fail   = 0;
  int wren_cycles = 0;
  int seen_3000   = 0;
  int wren_base;

  logic [31:0] mem_arr [0:255];
  bit          mem_init = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: samples address/write at the edge, data out one cycle later.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
      mem_arr[0] <= 32'h0050_0093;
      mem_arr[4] <= 32'h1234_5678;
      mem_init   <= 1'b1;
    end else begin
      if (bus.mem_wren) mem_arr[bus.mem_address[9:2]] <= bus.mem_data_in;
      bus.mem_data_out <= mem_arr[bus.mem_address[9:2]];
    end
  end

  always @(negedge clk) begin
    if (bus.mem_wren) wren_cycles <= wren_cycles + 1;
    if (bus.mem_address == 32'h0000_3000) seen_3000 <= seen_3000 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_funct3 = 3'b010;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_mem_address", bus.mem_address, 32'h0);
    check_eq("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    check_eq("rst_mem_data_in", bus.mem_data_in, 32'h0);
    check_eq("rst_mem_funct3", 32'(bus.mem_funct3), 32'd2);
    check_eq("rst_rvalids", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
    check_eq("rst_rdata_or", bus.if_rdata | bus.d_rdata, 32'h0);
    check_eq("rst_gnts_idle_noreq", 32'({bus.if_gnt, bus.d_gnt}), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Single fetch
    next_cycle();
    bus.if_addr = 32'h0000_1000;
    bus.if_req  = 1'b1;
    @(negedge clk);
    check_eq("f1_if_gnt_N", 32'(bus.if_gnt), 32'd1);
    check_eq("f1_d_gnt_N", 32'(bus.d_gnt), 32'd0);
    next_cycle();
    bus.if_req  = 1'b0;
    bus.if_addr = 32'hFFFF_FFF0;
    @(negedge clk);
    check_eq("f1_mem_address_N1", bus.mem_address, 32'h0000_1000);
    check_eq("f1_mem_wren_N1", 32'(bus.mem_wren), 32'd0);
    check_eq("f1_if_rvalid_N1", 32'(bus.if_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("f1_if_rvalid_N2", 32'(bus.if_rvalid), 32'd1);
    check_eq("f1_if_rdata_N2", bus.if_rdata, 32'h0050_0093);
    check_eq("f1_d_rvalid_N2", 32'(bus.d_rvalid), 32'd0);
    check_eq("f1_d_rdata_N2", bus.d_rdata, 32'h0);
    next_cycle();
    @(negedge clk);
    check_eq("f1_if_rvalid_N3", 32'(bus.if_rvalid), 32'd0);

    // Store then load of the same word
    wren_base = wren_cycles;
    next_cycle();
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_addr   = 32'h0000_2004;
    bus.d_wdata  = 32'hDEAD_BEEF;
    bus.d_funct3 = 3'b010;
    @(negedge clk);
    check_eq("st_d_gnt_N", 32'(bus.d_gnt), 32'd1);
    check_eq("st_if_gnt_N", 32'(bus.if_gnt), 32'd0);
    next_cycle();
    bus.d_we    = 1'b0;
    bus.d_wdata = 32'h0;
    @(negedge clk);
    check_eq("st_mem_wren_N1", 32'(bus.mem_wren), 32'd1);
    check_eq("st_mem_data_in_N1", bus.mem_data_in, 32'hDEAD_BEEF);
    check_eq("st_mem_address_N1", bus.mem_address, 32'h0000_2004);
    check_eq("st_d_gnt_N1", 32'(bus.d_gnt), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("st_ack_N2", 32'(bus.d_rvalid), 32'd1);
    check_eq("ld_d_gnt_N2", 32'(bus.d_gnt), 32'd1);
    check_eq("st_mem_wren_N2", 32'(bus.mem_wren), 32'd0);
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check_eq("ld_mem_wren_N3", 32'(bus.mem_wren), 32'd0);
    check_eq("ld_d_rvalid_N3", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("ld_d_rvalid_N4", 32'(bus.d_rvalid), 32'd1);
    check_eq("ld_d_rdata_N4", bus.d_rdata, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    check_eq("ld_d_rvalid_N5", 32'(bus.d_rvalid), 32'd0);
    check_eq("st_wren_one_cycle", 32'(wren_cycles - wren_base), 32'd1);

`ifdef MEM_ARB_RR_EN
    // Round-robin: fresh reset, then both requesters held for 8 cycles
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n      = 1'b1;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_1010;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h0000_2004;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_g;
      case (i)
        0:       exp_g = 2'b10;
        2:       exp_g = 2'b01;
        4:       exp_g = 2'b10;
        6:       exp_g = 2'b01;
        default: exp_g = 2'b00;
      endcase
      @(negedge clk);
      check_eq($sformatf("rr_gnt_c%0d", i), 32'({bus.if_gnt, bus.d_gnt}), 32'(exp_g));
      next_cycle();
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (3) next_cycle();
`else
    // Simultaneous requests with fixed D-over-IF priority
    next_cycle();
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_1010;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h0000_2004;
    bus.d_funct3 = 3'b000;
    @(negedge clk);
    check_eq("pr_gnts_N", 32'({bus.if_gnt, bus.d_gnt}), 32'd1);
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check_eq("pr_if_gnt_N1", 32'(bus.if_gnt), 32'd0);
    check_eq("pr_mem_funct3_N1", 32'(bus.mem_funct3), 32'd0);
    check_eq("pr_mem_address_N1", bus.mem_address, 32'h0000_2004);
    next_cycle();
    @(negedge clk);
    check_eq("pr_if_gnt_N2", 32'(bus.if_gnt), 32'd1);
    check_eq("pr_d_rvalid_N2", 32'(bus.d_rvalid), 32'd1);
    check_eq("pr_d_rdata_N2", bus.d_rdata, 32'hDEAD_BEEF);
    check_eq("pr_if_rvalid_N2", 32'(bus.if_rvalid), 32'd0);
    next_cycle();
    bus.if_req   = 1'b0;
    bus.d_funct3 = 3'b010;
    @(negedge clk);
    check_eq("pr_mem_address_N3", bus.mem_address, 32'h0000_1010);
    check_eq("pr_mem_funct3_N3", 32'(bus.mem_funct3), 32'd2);
    check_eq("pr_mem_wren_N3", 32'(bus.mem_wren), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("pr_if_rvalid_N4", 32'(bus.if_rvalid), 32'd1);
    check_eq("pr_if_rdata_N4", bus.if_rdata, 32'h1234_5678);
    check_eq("pr_d_rvalid_N4", 32'(bus.d_rvalid), 32'd0);
    check_eq("pr_d_rdata_N4", bus.d_rdata, 32'h0);
    next_cycle();
`endif

    // Fetch request withdrawn while another access is in ACCESS
    next_cycle();
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h0000_2004;
    bus.d_funct3 = 3'b010;
    @(negedge clk);
    check_eq("wd_d_gnt", 32'(bus.d_gnt), 32'd1);
    next_cycle();
    bus.d_req   = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_3000;
    @(negedge clk);
    check_eq("wd_if_gnt_access", 32'(bus.if_gnt), 32'd0);
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clk);
    check_eq("wd_if_gnt_resp", 32'(bus.if_gnt), 32'd0);
    check_eq("wd_d_rvalid_resp", 32'(bus.d_rvalid), 32'd1);
    check_eq("wd_if_rvalid_resp", 32'(bus.if_rvalid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      check_eq($sformatf("wd_if_rvalid_after%0d", i), 32'(bus.if_rvalid), 32'd0);
    end
    check_eq("wd_no_fetch_3000", 32'(seen_3000), 32'd0);

    // Reset asserted during the ACCESS cycle of a store
    next_cycle();
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_addr   = 32'h0000_2008;
    bus.d_wdata  = 32'hA5A5_A5A5;
    bus.d_funct3 = 3'b010;
    @(negedge clk);
    check_eq("rs_d_gnt", 32'(bus.d_gnt), 32'd1);
    next_cycle();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    check_eq("rs_mem_wren_access", 32'(bus.mem_wren), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("rs_mem_wren_async", 32'(bus.mem_wren), 32'd0);
    check_eq("rs_mem_address", bus.mem_address, 32'h0);
    check_eq("rs_mem_data_in", bus.mem_data_in, 32'h0);
    check_eq("rs_mem_funct3", 32'(bus.mem_funct3), 32'd2);
    check_eq("rs_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("rs_rvalids_after%0d", i), 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
      check_eq($sformatf("rs_gnts_after%0d", i), 32'({bus.if_gnt, bus.d_gnt}), 32'd0);
      next_cycle();
    end
    // The abandoned store must not have reached memory
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_2008;
    @(negedge clk);
    check_eq("rs_ld_d_gnt", 32'(bus.d_gnt), 32'd1);
    next_cycle();
    bus.d_req = 1'b0;
    next_cycle();
    @(negedge clk);
    check_eq("rs_ld_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check_eq("rs_ld_d_rdata", bus.d_rdata, 32'h0);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single synchronous memory port of the multicycle RV32I core between instruction fetch and load/store traffic. It sits between the core's fetch/data request interfaces and `memory`. It sequences each access through a fixed three-state FSM and returns read data or a write acknowledge to the winning requester. The arbiter owns `mem_wren`, so no requester can write memory without a grant.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch granted this cycle (combinational).
- `if_rvalid`  out  1  fetch data valid, one-cycle pulse.
- `if_rdata`  out  DATA_W  fetch data; meaningful only with `if_rvalid`.
- `d_req`  in  1  data request; held with the `d_*` request fields until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_funct3`  in  3  access size/sign, passed to memory unchanged.
- `d_gnt`  out  1  data granted this cycle (combinational).
- `d_rvalid`  out  1  load data valid or store acknowledge, one-cycle pulse.
- `d_rdata`  out  DATA_W  load data.
- `mem_address`  out  ADDR_W  registered memory address.
- `mem_wren`  out  1  registered write enable.
- `mem_data_in`  out  DATA_W  registered write data.
- `mem_funct3`  out  3  registered access size.
- `mem_data_out`  in  DATA_W  memory read data, valid one cycle after the address is sampled.

## Operation
- FSM states:
  - `ARB_IDLE`: no access in flight.
  - `ARB_ACCESS`: `mem_*` outputs driven; memory samples them at the end of this cycle.
  - `ARB_RESP`: `mem_data_out` valid; the owner's `*_rvalid` = 1.
- Grant is allowed only in `ARB_IDLE` or `ARB_RESP`.
  - A grant moves the FSM to `ARB_ACCESS`.
  - Without a grant, `ARB_RESP` moves to `ARB_IDLE`.
  - `ARB_ACCESS` always moves to `ARB_RESP`.
- On a grant, the arbiter latches the winner's address, data, write enable and funct3 into `mem_*`. It also latches `owner` (IF or D).
  - A fetch forces `mem_wren` = 0 and `mem_funct3` = 3'b010.
- `mem_wren` is high only in `ARB_ACCESS` and only for a granted store. Outside `ARB_ACCESS` it is 0.
- In `ARB_RESP`:
  - `*_rdata` = `mem_data_out` for the owner.
  - The non-owner's `rdata` is 0 and its `rvalid` is 0.
  - Stores also pulse `d_rvalid`, which serves as the write acknowledge; `d_rdata` is don't-care in that case.
- Arbitration when both requests are high is fixed priority: D wins over IF.
- `*_gnt` never asserts without the matching `*_req`. At most one `gnt` is high per cycle.
- A request dropped before its grant is simply ignored; no state change results.
- Request fields are sampled only on the grant cycle. The requester may change or drop them afterwards.

## Timing
- Latency: grant in cycle N, then `ARB_ACCESS` in N+1, then `rvalid` in N+2.
- Throughput: one access per 2 cycles when requests are back-to-back, because the next grant overlaps `ARB_RESP`.
- Reset values:
  - State `ARB_IDLE` and `owner` = D.
  - `mem_address`, `mem_data_in` = 0; `mem_wren` = 0; `mem_funct3` = 3'b010.
  - All `gnt`/`rvalid` = 0 and all `rdata` = 0.
- Reset asserted mid-access: the in-flight access is abandoned. `mem_wren` drops immediately (asynchronously). No `rvalid` is produced after reset release.
- Address wrap-around is not the arbiter's concern; addresses pass through unmodified.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests, the requester that is not `last_owner` wins.
  - `last_owner` updates on every grant and resets to D, so the first tie after reset grants IF.
  - A single requester is always granted regardless of `last_owner`.
- Not defined: fixed D-over-IF priority as described above, and no `last_owner` register exists.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` enum {`ARB_IDLE`, `ARB_ACCESS`, `ARB_RESP`}.
  - `arb_owner_t` enum {`OWN_IF`, `OWN_D`}.
  - Constant `FUNCT3_WORD` = 3'b010.
- One sub-module, `arb_pick`: purely combinational. Inputs are the two requests, `last_owner`, and a `grant_ok` enable. Outputs are the two one-hot grants. This confines the `MEM_ARB_RR_EN` difference to a single place.

## Test plan
- Single fetch: `if_req` with `if_addr` = 0x1000 while IDLE, memory word = 0x00500093 → `if_gnt` in N; `mem_address` = 0x1000 and `mem_wren` = 0 in N+1; `if_rvalid` with `if_rdata` = 0x00500093 in N+2.
- Store then load: store `d_addr` = 0x2004, `d_wdata` = 0xDEADBEEF, `d_funct3` = 3'b010, followed by a load of the same address → `mem_wren` high for exactly one cycle; store ack `d_rvalid` at N+2; load returns 0xDEADBEEF at N+4.
- Simultaneous requests with fixed priority: `if_req` and `d_req` both high from IDLE → `d_gnt` in N, `if_gnt` in N+2, `if_rvalid` in N+4.
- Simultaneous requests with `MEM_ARB_RR_EN`, both held high for 8 cycles after reset → grants alternate IF, D, IF, D, one grant every 2 cycles.
- Reset in `ARB_ACCESS` during a store to 0x2008 → `mem_wren` falls without waiting for a clock edge; no `d_rvalid`; after release the FSM is IDLE and all outputs are at their reset values.
- Request withdrawn: `if_req` pulsed high for one cycle while another access is in `ARB_ACCESS` → no `if_gnt`, no `if_rvalid`, and memory sees no fetch to that address.
